fq_tagger: RTL

//  Upstream stage of the fair-queue picker. Accepts packet descriptors (size

---
 rtl/fq_tagger.sv | 101 ++++++++++
 1 files changed

// File: rtl/fq_tagger.sv
// ============================================================================
// Module   : fq_tagger
// Brief    : Per-flow head-of-line store that stamps descriptors with virtual
//            finish tags and tracks virtual time for the fair-queue picker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fq_tagger #(
   parameter int NUM_IN_LOG2 = 3,
   localparam int N = 2 ** NUM_IN_LOG2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            in_valid,
   input  logic [N-1:0][7:0]       in_size,
   output logic [N-1:0]            in_ready,
   output logic [N-1:0][31:0]      count,
   output logic [N-1:0]            valid_o,
   output logic [N-1:0][7:0]       head_size,
   input  logic [NUM_IN_LOG2-1:0]  pick,
   input  logic                    pick_valid,
   output logic [31:0]             vtime,
   output logic                    pick_err
);

   logic [N-1:0]        r_hol_v;
   logic [N-1:0][31:0]  r_hol_tag;
   logic [N-1:0][7:0]   r_hol_size;
   logic [N-1:0][31:0]  r_last_finish;
   logic [31:0]         r_vtime;
   logic                r_pick_err;

   logic [N-1:0]        w_pop;
   logic [N-1:0]        w_accept;
   logic [N-1:0][31:0]  w_tag;
   logic                w_pop_any;
   logic                w_pick_empty;
   logic [31:0]         w_vtime_nxt;

   // Serial-number compare: a is strictly ahead of b across 32-bit wrap.
   function automatic logic wrap_gt(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return !d[31] && (d != 32'd0);
   endfunction

   always_comb begin
      w_pop    = '0;
      w_accept = '0;
      w_tag    = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         w_pop[i]    = pick_valid && (pick == NUM_IN_LOG2'(i)) && r_hol_v[i];
         in_ready[i] = !r_hol_v[i] || w_pop[i];
         w_accept[i] = in_valid[i] && in_ready[i];
         w_tag[i]    = (wrap_gt(r_last_finish[i], r_vtime) ? r_last_finish[i] : r_vtime)
                       + {24'd0, in_size[i]};
      end
      w_pop_any    = |w_pop;
      w_pick_empty = pick_valid && !r_hol_v[pick];
      w_vtime_nxt  = r_vtime;
      if (w_pop_any && wrap_gt(r_hol_tag[pick], r_vtime))
         w_vtime_nxt = r_hol_tag[pick];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hol_v       <= '0;
         r_hol_tag     <= '0;
         r_hol_size    <= '0;
         r_last_finish <= '0;
         r_vtime       <= '0;
         r_pick_err    <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            // A same-cycle refill overrides the pop and keeps the flow occupied.
            if (w_accept[i]) begin
               r_hol_v[i]       <= 1'b1;
               r_hol_tag[i]     <= w_tag[i];
               r_hol_size[i]    <= in_size[i];
               r_last_finish[i] <= w_tag[i];
            end else if (w_pop[i]) begin
               r_hol_v[i] <= 1'b0;
            end
         end
         r_vtime <= w_vtime_nxt;
         if (w_pick_empty)
            r_pick_err <= 1'b1;
      end
   end

   assign count     = r_hol_tag;
   assign valid_o   = r_hol_v;
   assign head_size = r_hol_size;
   assign vtime     = r_vtime;
   assign pick_err  = r_pick_err;

endmodule

`default_nettype wire
